vga_sprite_compositor: RTL and testbench
========================================

Name: vga_sprite_compositor

Overview:
- Parametrised next-generation VGA pixel pipeline.
- Generates sync timing for any resolution and drives a framebuffer read address.
- Composites one movable, clipped square sprite over a selectable background (framebuffer image or solid colour).
- Outputs sync, blank and RGB, all aligned to the framebuffer read latency.
- Sits between the framebuffer/palette ROM path and the DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SPRITE_SIZE, 128, sprite edge length in pixels (>=1)
- RD_LAT, 2, framebuffer+palette read latency in clocks (>=1)
- ADDR_W, 19, framebuffer address width (>= clog2(H_ACTIVE*V_ACTIVE))

Ports:
- iVGA_CLK  in  1  pixel clock; the only clock
- iRST_n  in  1  reset, asynchronous assert, active-low
- bg_mode  in  3  background select (see Behaviour)
- sprite_en  in  1  sprite enable
- sprite_x  in  11  sprite left column
- sprite_y  in  10  sprite top line
- sprite_color  in  24  sprite colour, {b,g,r}
- fb_addr  out  ADDR_W  framebuffer read address
- fb_q  in  24  framebuffer pixel {b,g,r}; valid RD_LAT clocks after fb_addr
- frame_start  out  1  one-clock pulse on the first active pixel of a frame (undelayed)
- oHS  out  1  horizontal sync, active-low
- oVS  out  1  vertical sync, active-low
- oBLANK_n  out  1  high during visible pixels
- r_data, g_data, b_data  out  8 each  pixel colour

Behaviour:
- Reset (async on iRST_n low):
  - h_cnt = v_cnt = 0; fb_addr = 0; frame_start = 0.
  - oHS = oVS = 1; oBLANK_n = 0; RGB = 0.
  - Shadow registers cleared (sprite disabled, bg_mode 0).
  - All pipeline stages flushed to the blank state.
- Counters:
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
  - h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Raw timing (stage 0):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_n is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_n is low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Address:
  - fb_addr is a registered incrementing counter. It is 0 at h=0,v=0 and increments by 1 after each active pixel, so the active pixel at (x,y) presents y*H_ACTIVE+x.
  - No multipliers or dividers.
  - It holds its value during blanking and reloads 0 at the last clock of the frame.
- Shadow latch:
  - sprite_en/x/y/color and bg_mode are sampled only on the last clock of the frame (h=H_TOTAL-1, v=V_TOTAL-1).
  - Input changes mid-frame never tear the image.
- Sprite hit:
  - hit = sprite_en && x in [sx, sx+SIZE-1] && y in [sy, sy+SIZE-1].
  - Use unsigned compare with widths extended by 1 bit so that sx+SIZE cannot overflow.
  - The sprite is clipped at the right/bottom edges with no wrap-around. Fully off-screen means no hit.
- Background by bg_mode:
  - 0 = fb_q
  - 1 = black 000000
  - 2 = white FFFFFF
  - 3 = red (r=FF)
  - 4 = green (g=FF)
  - 5 = blue (b=FF)
  - 6–7 = fb_q
- Composite priority: sprite > background. Blanked pixels output RGB = 0.
- Pipeline:
  - Total latency PIPE = RD_LAT+1 clocks from stage 0 to the outputs.
  - hs_n, vs_n, active and hit are delayed through a PIPE-deep shift register, so sync, blank and colour for a given pixel appear on the same clock.
  - All outputs are registered on the rising edge of iVGA_CLK.
- frame_start:
  - High for exactly one clock when h_cnt=0 and v_cnt=0.
  - Not delayed; it is intended for game logic.
- Reset mid-frame: all outputs return immediately to their reset values. After release, timing restarts at (0,0). The first frame after reset uses default shadow values until the first end-of-frame latch.

Decomposition:
- Shared package vga_pkg:
  - BG_* mode encodings
  - colour constants (COL_BLACK, COL_WHITE, COL_RED, COL_GREEN, COL_BLUE)
  - 24-bit bgr pixel typedef
- One sub-module, vga_timing_gen:
  - holds h/v counters, raw hs_n/vs_n/active, end-of-frame and frame_start strobes
  - is parametrised by the eight timing parameters

Test Plan:
- Tiny timing (H 8/2/2/2, V 4/1/1/1, RD_LAT=2) with bg_mode=2 → oBLANK_n high 8 clocks per line for 4 lines per 7-line frame. oHS is low 2 clocks at line positions 10–11 (10+3 offset). RGB is FFFFFF while blank-high and 0 otherwise.
- bg_mode=0, fb_q modelled as a ROM returning fb_q = the address presented 2 clocks earlier → output pixel (x,y) shows value y*8+x. fb_addr reaches 31 at the last active pixel and is 0 at the next frame start.
- Sprite SIZE=2, sx=3, sy=1, colour 0000FF, bg black → only pixels (3..4, 1..2) are FF red. All other active pixels are 0.
- Clipping: sx=7, sy=3 → only pixel (7,3) is red. Setting sx=2000 → no sprite pixels appear and there is no wrap to column 0.
- Change sprite_x from 3 to 5 mid-frame → the current frame is unchanged. The next frame shows the sprite at columns 5–6.
- Assert iRST_n low for 3 clocks mid-line → outputs are 0/1/1/0 (RGB/HS/VS/BLANK_n) asynchronously. After release, frame_start pulses on the first clock and the frame restarts at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sprite compositor.
// Pixels are packed {b,g,r}, one byte per channel.
package vga_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [2:0] {
        BG_FB      = 3'd0,
        BG_BLACK   = 3'd1,
        BG_WHITE   = 3'd2,
        BG_RED     = 3'd3,
        BG_GREEN   = 3'd4,
        BG_BLUE    = 3'd5,
        BG_FB_ALT6 = 3'd6,
        BG_FB_ALT7 = 3'd7
    } bg_mode_e;

    localparam pixel_t COL_BLACK = 24'h000000;
    localparam pixel_t COL_WHITE = 24'hFFFFFF;
    localparam pixel_t COL_RED   = 24'h0000FF;
    localparam pixel_t COL_GREEN = 24'h00FF00;
    localparam pixel_t COL_BLUE  = 24'hFF0000;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic active;
        logic hit;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_IDLE = '{
        hs_n: 1'b1, vs_n: 1'b1, active: 1'b0, hit: 1'b0
    };

    function automatic pixel_t bg_pixel(bg_mode_e mode, pixel_t fb);
        pixel_t px;
        case (mode)
            BG_BLACK: px = COL_BLACK;
            BG_WHITE: px = COL_WHITE;
            BG_RED:   px = COL_RED;
            BG_GREEN: px = COL_GREEN;
            BG_BLUE:  px = COL_BLUE;
            default:  px = fb;
        endcase
        return px;
    endfunction

endpackage

// File: rtl/vga_sprite_compositor_if.sv
// Framebuffer read port: address out, palette-resolved pixel back.
// The pixel returns a fixed number of clocks after the address.
interface vga_sprite_compositor_if #(
    parameter int ADDR_W = 19
);
    import vga_pkg::*;

    logic [ADDR_W-1:0] fb_addr;
    pixel_t            fb_q;

    modport master (output fb_addr, input fb_q);
    modport slave  (input fb_addr, output fb_q);

endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters and raw (undelayed) sync/active strobes.
// eof marks the last clock of the frame for shadow/address reloads.
module vga_timing_gen #(
    parameter  int H_ACTIVE = 640,
    parameter  int H_FP     = 16,
    parameter  int H_SYNC   = 96,
    parameter  int H_BP     = 48,
    parameter  int V_ACTIVE = 480,
    parameter  int V_FP     = 10,
    parameter  int V_SYNC   = 2,
    parameter  int V_BP     = 33,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          hs_n,
    output logic          vs_n,
    output logic          active,
    output logic          eof,
    output logic          frame_start
);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_last, v_last;
    logic [31:0]   hx, vy;

    always_comb begin
        hx      = 32'(h_cnt_q);
        vy      = 32'(v_cnt_q);
        h_last  = hx == 32'(H_TOTAL - 1);
        v_last  = vy == 32'(V_TOTAL - 1);
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    assign active = (hx < 32'(H_ACTIVE)) && (vy < 32'(V_ACTIVE));
    assign hs_n   = !((hx >= 32'(H_ACTIVE + H_FP)) &&
                      (hx <  32'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_n   = !((vy >= 32'(V_ACTIVE + V_FP)) &&
                      (vy <  32'(V_ACTIVE + V_FP + V_SYNC)));
    assign eof    = h_last && v_last;
    // Counters sit at (0,0) during reset, so the strobe is held off there.
    assign frame_start = rst_n && (hx == 32'd0) && (vy == 32'd0);

endmodule

// File: rtl/vga_sprite_compositor.sv
// VGA pipeline: raster timing, framebuffer addressing, frame-shadowed
// sprite/background selection, outputs aligned to the read latency.
module vga_sprite_compositor
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SPRITE_SIZE = 128,
    parameter int RD_LAT      = 2,
    parameter int ADDR_W      = 19
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic [2:0]  bg_mode,
    input  logic        sprite_en,
    input  logic [10:0] sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [23:0] sprite_color,
    vga_sprite_compositor_if.master fb,
    output logic        frame_start,
    output logic        oHS,
    output logic        oVS,
    output logic        oBLANK_n,
    output logic [7:0]  r_data,
    output logic [7:0]  g_data,
    output logic [7:0]  b_data
);

    localparam int PIPE = RD_LAT + 1;
    localparam int HW   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hs_n, vs_n, active, eof;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (iVGA_CLK),
        .rst_n       (iRST_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .active      (active),
        .eof         (eof),
        .frame_start (frame_start)
    );

    logic                   sh_en_q, sh_en_d;
    logic [10:0]            sh_x_q, sh_x_d;
    logic [9:0]             sh_y_q, sh_y_d;
    pixel_t                 sh_col_q, sh_col_d;
    bg_mode_e               sh_bg_q, sh_bg_d;
    logic [ADDR_W-1:0]      fb_addr_q, fb_addr_d;
    vga_ctrl_t [PIPE-1:0]   ctrl_q, ctrl_d;
    pixel_t                 rgb_q, rgb_d;

    logic [11:0] hx, sx_lo, sx_hi;
    logic [10:0] vy, sy_lo, sy_hi;
    logic        hit;
    vga_ctrl_t   stage0, tap;

    always_comb begin
        sh_en_d  = sh_en_q;
        sh_x_d   = sh_x_q;
        sh_y_d   = sh_y_q;
        sh_col_d = sh_col_q;
        sh_bg_d  = sh_bg_q;
        if (eof) begin
            sh_en_d  = sprite_en;
            sh_x_d   = sprite_x;
            sh_y_d   = sprite_y;
            sh_col_d = sprite_color;
            sh_bg_d  = bg_mode_e'(bg_mode);
        end
    end

    // One spare bit keeps sx+SIZE from wrapping back onto column 0.
    always_comb begin
        hx    = 12'(h_cnt);
        vy    = 11'(v_cnt);
        sx_lo = {1'b0, sh_x_q};
        sy_lo = {1'b0, sh_y_q};
        sx_hi = sx_lo + 12'(SPRITE_SIZE);
        sy_hi = sy_lo + 11'(SPRITE_SIZE);
        hit   = sh_en_q && (hx >= sx_lo) && (hx < sx_hi) &&
                (vy >= sy_lo) && (vy < sy_hi);
    end

    always_comb begin
        fb_addr_d = fb_addr_q;
        if (eof) begin
            fb_addr_d = '0;
        end else if (active) begin
            fb_addr_d = fb_addr_q + 1'b1;
        end
    end

    always_comb begin
        stage0 = '{hs_n: hs_n, vs_n: vs_n, active: active, hit: hit};
        ctrl_d = {ctrl_q[PIPE-2:0], stage0};
        tap    = ctrl_q[RD_LAT-1];
        rgb_d  = COL_BLACK;
        if (tap.active) begin
            rgb_d = tap.hit ? sh_col_q : bg_pixel(sh_bg_q, fb.fb_q);
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sh_en_q   <= 1'b0;
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_col_q  <= COL_BLACK;
            sh_bg_q   <= BG_FB;
            fb_addr_q <= '0;
            ctrl_q    <= {PIPE{CTRL_IDLE}};
            rgb_q     <= COL_BLACK;
        end else begin
            sh_en_q   <= sh_en_d;
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            sh_col_q  <= sh_col_d;
            sh_bg_q   <= sh_bg_d;
            fb_addr_q <= fb_addr_d;
            ctrl_q    <= ctrl_d;
            rgb_q     <= rgb_d;
        end
    end

    assign fb.fb_addr = fb_addr_q;
    assign oHS        = ctrl_q[PIPE-1].hs_n;
    assign oVS        = ctrl_q[PIPE-1].vs_n;
    assign oBLANK_n   = ctrl_q[PIPE-1].active;
    assign r_data     = rgb_q[7:0];
    assign g_data     = rgb_q[15:8];
    assign b_data     = rgb_q[23:16];

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for the compositor on a tiny 14x7 raster,
// 8x4 visible, 2x2 sprite, two-clock framebuffer latency.
module tb_vga_sprite_compositor;

    localparam int HT  = 14;
    localparam int VT  = 7;
    localparam int FR  = HT * VT;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  bg_mode = 3'd0;
    logic        sprite_en = 1'b0;
    logic [10:0] sprite_x = '0;
    logic [9:0]  sprite_y = '0;
    logic [23:0] sprite_color = '0;
    logic        frame_start, hs, vs, blank_n;
    logic [7:0]  r, g, b;
    logic [5:0]  a1;
    int          pos = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    vga_sprite_compositor_if #(.ADDR_W(6)) fb_if ();

    vga_sprite_compositor #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SPRITE_SIZE (2), .RD_LAT (2), .ADDR_W (6)
    ) dut (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .bg_mode      (bg_mode),
        .sprite_en    (sprite_en),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_color (sprite_color),
        .fb           (fb_if),
        .frame_start  (frame_start),
        .oHS          (hs),
        .oVS          (vs),
        .oBLANK_n     (blank_n),
        .r_data       (r),
        .g_data       (g),
        .b_data       (b)
    );

    always #5 clk = ~clk;

    // ROM model: returns the address presented two clocks earlier.
    always @(posedge clk) begin
        a1 <= fb_if.fb_addr;
        fb_if.fb_q <= 24'(a1);
    end

    function automatic logic [23:0] model_rgb(int x, int y, logic [2:0] m,
                                              bit en, int sx, int sy,
                                              logic [23:0] col);
        if (x >= 8 || y >= 4) return 24'h0;
        if (en && x >= sx && x < sx + 2 && y >= sy && y < sy + 2) return col;
        case (m)
            3'd1: return 24'h000000;
            3'd2: return 24'hFFFFFF;
            3'd3: return 24'h0000FF;
            3'd4: return 24'h00FF00;
            3'd5: return 24'hFF0000;
            default: return 24'(y * 8 + x);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        pos++;
        @(negedge clk);
    endtask

    task automatic goto_pos(int t);
        while (pos < t) tick();
    endtask

    task automatic set_inputs(logic [2:0] m, bit en, int sx, int sy,
                              logic [23:0] col);
        bg_mode = m;
        sprite_en = en;
        sprite_x = 11'(sx);
        sprite_y = 10'(sy);
        sprite_color = col;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_inputs(3'd0, 1'b0, 0, 0, 24'h0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({hs, vs, blank_n} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_sync got=%b exp=110", {hs, vs, blank_n});
        end
        n_checks++;
        if ({b, g, r} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_rgb got=%h exp=000000", {b, g, r});
        end
        n_checks++;
        if (fb_if.fb_addr !== 6'd0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_addr_fs got=%0d/%b exp=0/0",
                     fb_if.fb_addr, frame_start);
        end
        #1 rst_n = 1'b1;
        pos = 0;
        #1;
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_fs got=%b exp=1", frame_start);
        end
    endtask

    task automatic test_timing_white;
        int f, nb, nh, nv, x, y;
        logic [23:0] er;
        set_inputs(3'd2, 1'b0, 0, 0, 24'h0);
        f = pos / FR + 1;
        goto_pos(f * FR + LAT);
        nb = 0; nh = 0; nv = 0;
        for (int i = 0; i < FR; i++) begin
            x = i % HT;
            y = i / HT;
            er = model_rgb(x, y, 3'd2, 1'b0, 0, 0, 24'h0);
            n_checks++;
            if (blank_n !== (x < 8 && y < 4) || hs !== !(x == 10 || x == 11) ||
                vs !== !(y == 5) || {b, g, r} !== er) begin
                n_fail++;
                $display("FAIL timing_px(%0d,%0d) got=%b%b%b/%h exp=%b%b%b/%h",
                         x, y, blank_n, hs, vs, {b, g, r},
                         (x < 8 && y < 4), !(x == 10 || x == 11), !(y == 5), er);
            end
            nb += int'(blank_n);
            nh += int'(!hs);
            nv += int'(!vs);
            tick();
        end
        n_checks++;
        if (nb != 32 || nh != 14 || nv != 14) begin
            n_fail++;
            $display("FAIL timing_counts got=%0d/%0d/%0d exp=32/14/14",
                     nb, nh, nv);
        end
    endtask

    task automatic test_frame_start_addr;
        int f, h, v, ii, ea;
        f = pos / FR + 1;
        goto_pos(f * FR);
        for (int i = 0; i <= FR; i++) begin
            ii = i % FR;
            h = ii % HT;
            v = ii / HT;
            ea = (v >= 4) ? 32 : v * 8 + ((h < 8) ? h : 8);
            n_checks++;
            if (frame_start !== (ii == 0) || int'(fb_if.fb_addr) != ea) begin
                n_fail++;
                $display("FAIL addr_fs(%0d,%0d) got=%b/%0d exp=%b/%0d",
                         h, v, frame_start, fb_if.fb_addr, (ii == 0), ea);
            end
            tick();
        end
    endtask

    task automatic test_fb_image;
        int f, x, y;
        logic [23:0] er;
        set_inputs(3'd0, 1'b0, 0, 0, 24'h0);
        f = pos / FR + 1;
        goto_pos(f * FR + LAT);
        for (int i = 0; i < FR; i++) begin
            x = i % HT;
            y = i / HT;
            er = model_rgb(x, y, 3'd0, 1'b0, 0, 0, 24'h0);
            n_checks++;
            if ({b, g, r} !== er) begin
                n_fail++;
                $display("FAIL fb_px(%0d,%0d) got=%h exp=%h", x, y, {b, g, r}, er);
            end
            tick();
        end
    endtask

    task automatic test_sprite_case(string nm, int sx, int sy, int n_red);
        int f, x, y, nr;
        logic [23:0] er;
        set_inputs(3'd1, 1'b1, sx, sy, 24'h0000FF);
        f = pos / FR + 1;
        goto_pos(f * FR + LAT);
        nr = 0;
        for (int i = 0; i < FR; i++) begin
            x = i % HT;
            y = i / HT;
            er = model_rgb(x, y, 3'd1, 1'b1, sx, sy, 24'h0000FF);
            n_checks++;
            if ({b, g, r} !== er) begin
                n_fail++;
                $display("FAIL %s_px(%0d,%0d) got=%h exp=%h",
                         nm, x, y, {b, g, r}, er);
            end
            nr += int'({b, g, r} == 24'h0000FF);
            tick();
        end
        n_checks++;
        if (nr != n_red) begin
            n_fail++;
            $display("FAIL %s_count got=%0d exp=%0d", nm, nr, n_red);
        end
    endtask

    task automatic test_no_tear;
        int f, x, y;
        logic [23:0] er;
        set_inputs(3'd1, 1'b1, 3, 1, 24'h0000FF);
        f = pos / FR + 1;
        goto_pos(f * FR + LAT);
        for (int i = 0; i < 2 * FR; i++) begin
            x = (i % FR) % HT;
            y = (i % FR) / HT;
            if (i == 20) sprite_x = 11'd5;
            er = model_rgb(x, y, 3'd1, 1'b1, (i < FR) ? 3 : 5, 1, 24'h0000FF);
            n_checks++;
            if ({b, g, r} !== er) begin
                n_fail++;
                $display("FAIL no_tear_f%0d_px(%0d,%0d) got=%h exp=%h",
                         i / FR, x, y, {b, g, r}, er);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        int f, x, y;
        logic [23:0] er;
        set_inputs(3'd2, 1'b1, 3, 1, 24'h00FF00);
        f = pos / FR + 1;
        goto_pos(f * FR + LAT + 16);
        n_checks++;
        if (blank_n !== 1'b1 || {b, g, r} !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL pre_reset got=%b/%h exp=1/ffffff", blank_n, {b, g, r});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({b, g, r} !== 24'h0 || {hs, vs, blank_n} !== 3'b110 ||
            fb_if.fb_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async got=%h/%b/%0d exp=000000/110/0",
                     {b, g, r}, {hs, vs, blank_n}, fb_if.fb_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({b, g, r} !== 24'h0 || {hs, vs, blank_n} !== 3'b110 ||
                frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_hold%0d got=%h/%b/%b exp=000000/110/0",
                         k, {b, g, r}, {hs, vs, blank_n}, frame_start);
            end
        end
        #1 rst_n = 1'b1;
        pos = 0;
        #1;
        n_checks++;
        if (frame_start !== 1'b1 || fb_if.fb_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL restart_fs got=%b/%0d exp=1/0",
                     frame_start, fb_if.fb_addr);
        end
        goto_pos(LAT);
        for (int i = 0; i < FR; i++) begin
            x = i % HT;
            y = i / HT;
            er = model_rgb(x, y, 3'd0, 1'b0, 0, 0, 24'h0);
            n_checks++;
            if ({b, g, r} !== er || hs !== !(x == 10 || x == 11) ||
                vs !== !(y == 5)) begin
                n_fail++;
                $display("FAIL restart_px(%0d,%0d) got=%h/%b%b exp=%h/%b%b",
                         x, y, {b, g, r}, hs, vs, er,
                         !(x == 10 || x == 11), !(y == 5));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_timing_white();
        test_frame_start_addr();
        test_fb_image();
        test_sprite_case("sprite", 3, 1, 4);
        test_sprite_case("clip_corner", 7, 3, 1);
        test_sprite_case("clip_far", 2000, 0, 0);
        test_no_tear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
